bnn_window_gen: RTL and testbench
=================================

# bnn_window_gen

Sliding-window generator feeding the first convolution layer of the BNN accelerator. It accepts the 8-bit image stream row-major, one pixel per handshake, and buffers K-1 lines. For every position where a full KxK window lies inside the image, it presents that window in parallel to the conv stage. Backpressure from the conv stage stalls the image stream, and no pixel or window is ever dropped.

## Interface
Parameters:
- IMG_W, 28, image width in pixels
- IMG_H, 28, image height in pixels
- K, 5, window size (KxK)
- DW, 8, pixel width in bits (unsigned)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle pulse; begins a new frame
- pix_tvalid  in  1  image pixel valid
- pix_tdata  in  DW  image pixel
- pix_tready  out  1  pixel accepted when pix_tvalid && pix_tready
- win_valid  out  1  window valid; held until accepted
- win_data  out  K*K*DW  window; element (i,j) at [(i*K+j)*DW +: DW], i=0 top row, j=0 leftmost column
- win_ready  in  1  downstream accepts window
- win_row  out  5  top-left row index of the presented window
- win_col  out  5  top-left column index of the presented window
- frame_done  out  1  single-cycle pulse after the last window handshake

## Operation
- States:
  - IDLE: pix_tready=0.
  - RUN: accepts pixels.
  - FLUSH: last pixel taken; waits for the final window handshake.
- IDLE→RUN on start. Entering RUN clears the row/col counters and win_valid.
- RUN→FLUSH on acceptance of pixel (IMG_H-1, IMG_W-1).
- FLUSH→IDLE on the win_valid && win_ready handshake. The frame_done pulse is issued in the following cycle.
- On each accepted pixel at (r,c):
  - The column vector {lb[K-2][c], …, lb[0][c], pix} shifts into the KxK window register from the right; the oldest row is at the top.
  - Then lb[k+1][c] ← lb[k][c] and lb[0][c] ← pix.
  - c increments and wraps at IMG_W-1, with r incrementing on the wrap.
- A window is emitted when r ≥ K-1 && c ≥ K-1. Then win_row=r-(K-1) and win_col=c-(K-1).
- Windows per frame: (IMG_H-K+1)*(IMG_W-K+1), i.e. 576 for the defaults.
- Line buffers are not cleared. Coordinate gating guarantees no stale data is ever emitted.
- No arithmetic; pixels pass through unchanged.
- A start pulse in RUN or FLUSH restarts the frame: counters are cleared, win_valid drops, and any pending window is discarded.
- start in the same cycle as a pixel handshake: start wins and the pixel is not consumed (pix_tready=0 that cycle).

## Timing
- Reset values:
  - state=IDLE
  - pix_tready=0
  - win_valid=0
  - win_data=0
  - win_row=0, win_col=0
  - frame_done=0
- pix_tready = (state==RUN) && !start && (!win_valid || win_ready). This is combinational from registered state and win_ready.
- Latency: a window is registered and win_valid asserts in the cycle after the completing pixel handshake.
- win_valid && win_ready in the same cycle as a new completing pixel: the new window replaces the old one with no bubble. Sustained throughput is 1 pixel/cycle.
- win_valid && !win_ready: win_data, win_row and win_col are held stable, and pix_tready=0.
- Reset mid-frame: all outputs return to their reset values immediately (asynchronous); the next frame requires start.

## Structure
- Package bnn_pkg holds:
  - IMG_W, IMG_H, K, DW defaults
  - the state enum (IDLE, RUN, FLUSH)
- Sub-module bnn_line_buffer: one IMG_W-deep, DW-wide line with a read-before-write port at address c. It is instantiated K-1 times in a chain.
- Top level holds the FSM, the counters, the window shift register and the output register.

## Test plan
- Ramp image (pixel = (r*28+c) mod 256), win_ready=1, continuous valid:
  - first win_valid one cycle after beat 117, with win_row=0, win_col=0, element(0,0)=0, element(4,4)=116;
  - last window at (23,23) with element(0,0)=155, element(4,4)=15;
  - exactly 576 windows, then one frame_done pulse.
- Random pix_tvalid gaps (50%): the window sequence and data are identical to the continuous run.
- win_ready held low for 10 cycles at window (0,3):
  - pix_tready=0 throughout, and win_data is stable;
  - after release, windows resume at (0,4) with none lost.
- start pulse at pixel 300 mid-frame, followed by a fresh ramp frame: the first window is again at (0,0) with element(4,4)=116, and 576 windows follow.
- rstn asserted mid-frame during win_valid=1: outputs return to reset values immediately; after start, the next frame is correct.
- Back-to-back frames (start issued in the frame_done cycle): two full frames of 576 windows each, with no spurious windows between them.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared defaults and FSM state encoding for the BNN sliding-window generator.
package bnn_pkg;

    localparam int IMG_W_DEF = 28;
    localparam int IMG_H_DEF = 28;
    localparam int K_DEF     = 5;
    localparam int DW_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/bnn_window_gen_if.sv
// Pixel stream in and KxK window out; master is the window generator side.
interface bnn_window_gen_if
    import bnn_pkg::*;
#(
    parameter int K  = K_DEF,
    parameter int DW = DW_DEF
) ();

    logic                pix_tvalid;
    logic [DW-1:0]       pix_tdata;
    logic                pix_tready;
    logic                win_valid;
    logic [K*K*DW-1:0]   win_data;
    logic                win_ready;
    logic [4:0]          win_row;
    logic [4:0]          win_col;

    modport master (
        input  pix_tvalid, pix_tdata, win_ready,
        output pix_tready, win_valid, win_data, win_row, win_col
    );

    modport slave (
        output pix_tvalid, pix_tdata, win_ready,
        input  pix_tready, win_valid, win_data, win_row, win_col
    );

endinterface

// File: rtl/bnn_line_buffer.sv
// One image line; read-before-write so the old column value is visible while the new one is written.
module bnn_line_buffer
    import bnn_pkg::*;
#(
    parameter int DEPTH = IMG_W_DEF,
    parameter int DW    = DW_DEF,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wr_data;
    end

endmodule

// File: rtl/bnn_window_gen.sv
// Sliding KxK window generator: K-1 line buffers, window shift register, registered output.
//   state | meaning
//   IDLE  | no frame active, pix_tready low
//   RUN   | accepting pixels, emitting windows
//   FLUSH | last pixel taken, waiting for final window handshake
module bnn_window_gen
    import bnn_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int K     = K_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    bnn_window_gen_if.master bus,
    output logic             frame_done
);

    localparam int CW = 5;

    state_e              state;
    logic [CW-1:0]       row_cnt, col_cnt;
    logic [DW-1:0]       win_sr  [K][K];
    logic [DW-1:0]       win_nxt [K][K];
    logic [DW-1:0]       col_vec [K];
    logic [DW-1:0]       lb_rd   [K-1];
    logic [K*K*DW-1:0]   win_data_nxt;
    logic                accept, emit, last_pix, win_hs;

    assign bus.pix_tready = (state == RUN) && !start && (!bus.win_valid || bus.win_ready);
    assign accept   = bus.pix_tvalid && bus.pix_tready;
    assign win_hs   = bus.win_valid && bus.win_ready;
    assign emit     = accept && (row_cnt >= CW'(K-1)) && (col_cnt >= CW'(K-1));
    assign last_pix = (row_cnt == CW'(IMG_H-1)) && (col_cnt == CW'(IMG_W-1));

    for (genvar k = 0; k < K-1; k++) begin : g_lb
        logic [DW-1:0] lb_in;
        if (k == 0) begin : g_head
            assign lb_in = bus.pix_tdata;
        end else begin : g_chain
            assign lb_in = lb_rd[k-1];
        end
        bnn_line_buffer #(.DEPTH(IMG_W), .DW(DW), .AW(CW)) u_lb (
            .clk     (clk),
            .we      (accept),
            .addr    (col_cnt),
            .wr_data (lb_in),
            .rd_data (lb_rd[k])
        );
    end

    // Oldest line lands in the top row, the incoming pixel in the bottom row.
    for (genvar i = 0; i < K; i++) begin : g_col
        if (i == K-1) begin : g_pix
            assign col_vec[i] = bus.pix_tdata;
        end else begin : g_line
            assign col_vec[i] = lb_rd[K-2-i];
        end
    end

    always_comb begin
        win_data_nxt = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K-1; j++) win_nxt[i][j] = win_sr[i][j+1];
            win_nxt[i][K-1] = col_vec[i];
            for (int j = 0; j < K; j++) win_data_nxt[(i*K+j)*DW +: DW] = win_nxt[i][j];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++) win_sr[i][j] <= '0;
        end else if (accept) begin
            win_sr <= win_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            row_cnt       <= '0;
            col_cnt       <= '0;
            bus.win_valid <= 1'b0;
            bus.win_data  <= '0;
            bus.win_row   <= '0;
            bus.win_col   <= '0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (start) begin
                state         <= RUN;
                row_cnt       <= '0;
                col_cnt       <= '0;
                bus.win_valid <= 1'b0;
            end else begin
                if (accept) begin
                    if (col_cnt == CW'(IMG_W-1)) begin
                        col_cnt <= '0;
                        row_cnt <= row_cnt + 1'b1;
                    end else begin
                        col_cnt <= col_cnt + 1'b1;
                    end
                    if (last_pix) state <= FLUSH;
                end
                if (emit) begin
                    bus.win_valid <= 1'b1;
                    bus.win_data  <= win_data_nxt;
                    bus.win_row   <= row_cnt - CW'(K-1);
                    bus.win_col   <= col_cnt - CW'(K-1);
                end else if (win_hs) begin
                    bus.win_valid <= 1'b0;
                end
                if (state == FLUSH && win_hs) begin
                    state      <= IDLE;
                    frame_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bnn_window_gen.sv
// Scoreboard bench for bnn_window_gen: driver pushes expected windows, monitor pops on handshake.
module tb_bnn_window_gen;
    import bnn_pkg::*;

    localparam int W = 28, H = 28, K = 5, DW = 8, NWIN = 576, NPIX = W*H;
    localparam int VW = K*K*DW;

    logic clk = 1'b0, rstn = 1'b0, start = 1'b0;
    logic frame_done;

    bnn_window_gen_if #(.K(K), .DW(DW)) bus ();

    bnn_window_gen #(.IMG_W(W), .IMG_H(H), .K(K), .DW(DW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .bus        (bus),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]    row;
        logic [4:0]    col;
        logic [VW-1:0] data;
    } win_t;

    win_t          exp_q [$];
    win_t          m_a, m_e, first_w, last_w;
    logic [DW-1:0] img [H][W];
    int            n_checks = 0, n_fail = 0;
    int            win_cnt = 0, done_cnt = 0;

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout expected event", name);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "bounded wait expired");
    endtask

    always @(negedge clk) begin
        if (rstn && frame_done) done_cnt++;
        if (rstn && bus.win_valid && bus.win_ready) begin
            m_a.row  = bus.win_row;
            m_a.col  = bus.win_col;
            m_a.data = bus.win_data;
            if (exp_q.size() == 0) begin
                check_int("spurious_window", 1, 0);
            end else begin
                m_e = exp_q.pop_front();
                check_int("win_row", int'(m_a.row), int'(m_e.row));
                check_int("win_col", int'(m_a.col), int'(m_e.col));
                check_vec("win_data", m_a.data, m_e.data);
            end
            if (win_cnt == 0) first_w = m_a;
            last_w = m_a;
            win_cnt++;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_pixels(input int npix, input bit gaps);
        for (int idx = 0; idx < npix; idx++) begin
            int            r = idx / W;
            int            c = idx % W;
            int            n = 0;
            bit            got = 1'b0;
            logic [DW-1:0] p = DW'((r*W + c) % 256);
            win_t          e;
            img[r][c] = p;
            if (gaps && $urandom_range(0, 1) == 1) begin
                bus.pix_tvalid = 1'b0;
                @(posedge clk); #1;
            end
            bus.pix_tvalid = 1'b1;
            bus.pix_tdata  = p;
            while (!got) begin
                @(negedge clk);
                got = bus.pix_tready;
                @(posedge clk); #1;
                if (!got) begin
                    n++;
                    if (n > 500) timeout("pix_handshake");
                end
            end
            if (r >= K-1 && c >= K-1) begin
                e.row  = 5'(r - (K-1));
                e.col  = 5'(c - (K-1));
                e.data = '0;
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++)
                        e.data[(i*K+j)*DW +: DW] = img[r-(K-1)+i][c-(K-1)+j];
                exp_q.push_back(e);
            end
            if (idx == 115) check_int("pre_first_valid", int'(bus.win_valid), 0);
            if (idx == 116) begin
                check_int("first_valid_latency", int'(bus.win_valid), 1);
                check_int("first_valid_row", int'(bus.win_row), 0);
                check_int("first_valid_col", int'(bus.win_col), 0);
            end
        end
        bus.pix_tvalid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target) begin
            @(posedge clk); #1;
            n++;
            if (n > 3000) timeout("frame_done_wait");
        end
    endtask

    task automatic frame_checks();
        check_int("win_count", win_cnt, NWIN);
        check_int("first_row", int'(first_w.row), 0);
        check_int("first_col", int'(first_w.col), 0);
        check_int("first_e00", int'(first_w.data[7:0]), 0);
        check_int("first_e44", int'(first_w.data[199:192]), 116);
        check_int("last_row", int'(last_w.row), 23);
        check_int("last_col", int'(last_w.col), 23);
        check_int("last_e00", int'(last_w.data[7:0]), 155);
        check_int("last_e44", int'(last_w.data[199:192]), 15);
        check_int("queue_empty", exp_q.size(), 0);
    endtask

    task automatic run_frame(input bit gaps, input bit do_start);
        int base = done_cnt;
        win_cnt = 0;
        if (do_start) pulse_start();
        send_pixels(NPIX, gaps);
        wait_done(base + 1);
        repeat (5) @(posedge clk);
        #1;
        check_int("frame_done_once", done_cnt, base + 1);
        frame_checks();
    endtask

    task automatic stall_at_03();
        int            n = 0;
        logic [VW-1:0] held;
        while (!(bus.win_valid && bus.win_row == 5'd0 && bus.win_col == 5'd2)) begin
            @(posedge clk); #1;
            n++;
            if (n > 1000) timeout("stall_sync");
        end
        @(posedge clk); #1;
        bus.win_ready = 1'b0;
        check_int("stall_col", int'(bus.win_col), 3);
        held = bus.win_data;
        repeat (10) begin
            @(negedge clk);
            check_int("stall_tready", int'(bus.pix_tready), 0);
            check_int("stall_valid", int'(bus.win_valid), 1);
            check_vec("stall_data", bus.win_data, held);
        end
        @(posedge clk); #1;
        bus.win_ready = 1'b1;
    endtask

    initial begin
        int base;
        int n;
        bus.pix_tvalid = 1'b0;
        bus.pix_tdata  = '0;
        bus.win_ready  = 1'b1;
        #12;
        check_int("rst_tready", int'(bus.pix_tready), 0);
        check_int("rst_valid", int'(bus.win_valid), 0);
        check_vec("rst_data", bus.win_data, '0);
        check_int("rst_row", int'(bus.win_row), 0);
        check_int("rst_col", int'(bus.win_col), 0);
        check_int("rst_done", int'(frame_done), 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        bus.pix_tvalid = 1'b1;
        @(negedge clk);
        check_int("idle_tready", int'(bus.pix_tready), 0);
        @(posedge clk); #1;
        bus.pix_tvalid = 1'b0;

        // Continuous ramp, then random valid gaps.
        run_frame(1'b0, 1'b1);
        run_frame(1'b1, 1'b1);

        // Backpressure stall at window (0,3).
        base = done_cnt;
        win_cnt = 0;
        pulse_start();
        fork
            send_pixels(NPIX, 1'b0);
            stall_at_03();
        join
        wait_done(base + 1);
        #1;
        frame_checks();

        // Restart mid-frame with a pending window and a presented pixel.
        win_cnt = 0;
        pulse_start();
        send_pixels(300, 1'b0);
        bus.win_ready  = 1'b0;
        bus.pix_tvalid = 1'b1;
        bus.pix_tdata  = 8'h55;
        start = 1'b1;
        @(negedge clk);
        check_int("start_blocks_tready", int'(bus.pix_tready), 0);
        @(posedge clk); #1;
        start = 1'b0;
        bus.pix_tvalid = 1'b0;
        bus.win_ready  = 1'b1;
        check_int("restart_drops_valid", int'(bus.win_valid), 0);
        check_int("restart_pending", exp_q.size(), 1);
        exp_q.delete();
        run_frame(1'b0, 1'b0);

        // Asynchronous reset while a window is held.
        win_cnt = 0;
        pulse_start();
        send_pixels(150, 1'b0);
        bus.win_ready = 1'b0;
        #2;
        check_int("prereset_valid", int'(bus.win_valid), 1);
        rstn = 1'b0;
        #1;
        check_int("arst_tready", int'(bus.pix_tready), 0);
        check_int("arst_valid", int'(bus.win_valid), 0);
        check_vec("arst_data", bus.win_data, '0);
        check_int("arst_row", int'(bus.win_row), 0);
        check_int("arst_col", int'(bus.win_col), 0);
        check_int("arst_done", int'(frame_done), 0);
        exp_q.delete();
        @(posedge clk); #1;
        rstn = 1'b1;
        bus.win_ready = 1'b1;
        run_frame(1'b0, 1'b1);

        // Back-to-back frames, second start in the frame_done cycle.
        base = done_cnt;
        win_cnt = 0;
        pulse_start();
        send_pixels(NPIX, 1'b0);
        n = 0;
        while (!frame_done) begin
            @(posedge clk); #1;
            n++;
            if (n > 3000) timeout("b2b_done_wait");
        end
        start = 1'b1;
        check_int("b2b_frame_a_count", win_cnt, NWIN);
        win_cnt = 0;
        @(posedge clk); #1;
        start = 1'b0;
        send_pixels(NPIX, 1'b0);
        wait_done(base + 2);
        #1;
        check_int("b2b_done_count", done_cnt, base + 2);
        frame_checks();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
